// File: rtl/ps2_bcd_entry_ctrl.sv
// Two-digit BCD entry from PS/2 set-2 scan codes: digits, Backspace, Enter commit, break-code skipping.
// Optional Esc abort is compiled in with `define PS2_ESC_ABORT_EN.
module ps2_bcd_entry_ctrl #(
    parameter logic [7:0] MAX_VAL = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] scan_code,
    input  logic       enable,
    output logic [7:0] bcd_out,
    output logic       bcd_valid,
    output logic [1:0] digit_count,
    output logic       entry_err,
    output logic       entry_abort,
    output logic       busy
);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_ESC   = 8'h76;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_BREAK = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] acc;
    logic [1:0] count;
    logic       is_digit;
    logic [3:0] digit;

    assign digit_count = count;

`ifdef PS2_ESC_ABORT_EN
    logic abort_q;
    assign entry_abort = abort_q;
`else
    assign entry_abort = 1'b0;
`endif

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (scan_code)
            8'h45:   digit = 4'd0;
            8'h16:   digit = 4'd1;
            8'h1E:   digit = 4'd2;
            8'h26:   digit = 4'd3;
            8'h25:   digit = 4'd4;
            8'h2E:   digit = 4'd5;
            8'h36:   digit = 4'd6;
            8'h3D:   digit = 4'd7;
            8'h3E:   digit = 4'd8;
            8'h46:   digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    // Every output is registered, so all responses land one clock after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            acc       <= 8'h00;
            count     <= 2'd0;
            bcd_out   <= 8'h00;
            bcd_valid <= 1'b0;
            entry_err <= 1'b0;
            busy      <= 1'b0;
`ifdef PS2_ESC_ABORT_EN
            abort_q   <= 1'b0;
`endif
        end else begin
            bcd_valid <= 1'b0;
            entry_err <= 1'b0;
`ifdef PS2_ESC_ABORT_EN
            abort_q   <= 1'b0;
`endif
            if (!enable) begin
                state <= S_IDLE;
                acc   <= 8'h00;
                count <= 2'd0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_ENTRY;
                        acc   <= 8'h00;
                        count <= 2'd0;
                        busy  <= 1'b1;
                    end
                    // The byte after 0xF0 is the released key; drop it.
                    S_BREAK: begin
                        if (rx_done_tick) begin
                            state <= S_ENTRY;
                        end
                    end
                    S_ENTRY: begin
                        if (rx_done_tick) begin
                            if (scan_code == CODE_BREAK) begin
                                state <= S_BREAK;
                            end else if (scan_code == CODE_EXT) begin
                                state <= S_ENTRY;
                            end else if (is_digit) begin
                                if (count != 2'd2) begin
                                    acc   <= {acc[3:0], digit};
                                    count <= count + 2'd1;
                                end
                            end else if (scan_code == CODE_BKSP) begin
                                if (count != 2'd0) begin
                                    acc   <= {4'h0, acc[7:4]};
                                    count <= count - 2'd1;
                                end
                            end else if (scan_code == CODE_ENTER) begin
                                if (count != 2'd0) begin
                                    // BCD ordering matches binary ordering, so a plain compare works.
                                    if (acc <= MAX_VAL) begin
                                        bcd_out   <= acc;
                                        bcd_valid <= 1'b1;
                                    end else begin
                                        entry_err <= 1'b1;
                                    end
                                    acc   <= 8'h00;
                                    count <= 2'd0;
                                end
`ifdef PS2_ESC_ABORT_EN
                            end else if (scan_code == CODE_ESC) begin
                                acc     <= 8'h00;
                                count   <= 2'd0;
                                abort_q <= 1'b1;
`endif
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_bcd_entry_ctrl.sv
// Bench for ps2_bcd_entry_ctrl: directed vector table, hand sequences, and randomized codes
// checked against a digit-list reference model.
module tb_ps2_bcd_entry_ctrl;

    localparam logic [7:0] MAX_BCD = 8'h59;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] scan_code;
    logic       enable;
    logic [7:0] bcd_out;
    logic       bcd_valid;
    logic [1:0] digit_count;
    logic       entry_err;
    logic       entry_abort;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_bcd_entry_ctrl #(.MAX_VAL(MAX_BCD)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_done_tick(rx_done_tick),
        .scan_code   (scan_code),
        .enable      (enable),
        .bcd_out     (bcd_out),
        .bcd_valid   (bcd_valid),
        .digit_count (digit_count),
        .entry_err   (entry_err),
        .entry_abort (entry_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: an armed flag, a pending-release flag and the list of typed digits.
    bit         m_armed;
    bit         m_brk;
    int         m_dig[$];
    logic [7:0] m_out;
    bit         m_valid, m_err, m_abort;

    logic [7:0] dcodes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    function automatic int digit_of(logic [7:0] c);
        for (int i = 0; i < 10; i++) if (dcodes[i] == c) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_armed = 0; m_brk = 0; m_dig.delete(); m_out = 8'h00;
        m_valid = 0; m_err = 0; m_abort = 0;
    endfunction

    function automatic void model_step(bit en, bit tick, logic [7:0] code);
        int d, v, max_dec;
        m_valid = 0; m_err = 0; m_abort = 0;
        max_dec = int'(MAX_BCD[7:4]) * 10 + int'(MAX_BCD[3:0]);
        if (!en) begin
            m_armed = 0; m_brk = 0; m_dig.delete();
            return;
        end
        if (!m_armed) begin
            m_armed = 1; m_brk = 0; m_dig.delete();
            return;
        end
        if (!tick) return;
        if (m_brk) begin
            m_brk = 0;
            return;
        end
        d = digit_of(code);
        if (code == 8'hF0) m_brk = 1;
        else if (d >= 0) begin
            if (m_dig.size() < 2) m_dig.push_back(d);
        end else if (code == 8'h66) begin
            if (m_dig.size() > 0) void'(m_dig.pop_back());
        end else if (code == 8'h5A && m_dig.size() > 0) begin
            v = (m_dig.size() == 2) ? m_dig[0] * 10 + m_dig[1] : m_dig[0];
            if (v <= max_dec) begin
                m_out = 8'((v / 10) * 16 + (v % 10));
                m_valid = 1;
            end else m_err = 1;
            m_dig.delete();
        end
`ifdef PS2_ESC_ABORT_EN
        else if (code == 8'h76) begin
            m_dig.delete();
            m_abort = 1;
        end
`endif
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model.bcd_out", bcd_out, m_out);
        chk("model.bcd_valid", {7'd0, bcd_valid}, {7'd0, m_valid});
        chk("model.digit_count", {6'd0, digit_count}, 8'(m_dig.size()));
        chk("model.entry_err", {7'd0, entry_err}, {7'd0, m_err});
        chk("model.entry_abort", {7'd0, entry_abort}, {7'd0, m_abort});
        chk("model.busy", {7'd0, busy}, {7'd0, m_armed});
    endtask

    // Called at a falling edge: drive for the next rising edge, then check at the following falling edge.
    task automatic cycle(input bit en, input bit tick, input logic [7:0] code);
        enable = en; rx_done_tick = tick; scan_code = code;
        @(negedge clk);
        model_step(en, tick, code);
        check_model();
    endtask

    typedef struct {
        logic       en;
        logic       tick;
        logic [7:0] code;
        logic [7:0] bcd;
        logic       valid;
        logic [1:0] cnt;
        logic       err;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int en, input int tick, input int code, input int bcd,
                           input int valid, input int cnt, input int err, input int bsy);
        vec_t v;
        v.en = 1'(en); v.tick = 1'(tick); v.code = 8'(code); v.bcd = 8'(bcd);
        v.valid = 1'(valid); v.cnt = 2'(cnt); v.err = 1'(err); v.busy = 1'(bsy);
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rx_done_tick = 1'b0; scan_code = 8'h00;
        model_reset();

        add_vec(1,0,'h00, 'h00,0,0,0,1);
        add_vec(1,1,'h26, 'h00,0,1,0,1);
        add_vec(1,1,'hF0, 'h00,0,1,0,1);
        add_vec(1,1,'h26, 'h00,0,1,0,1);
        add_vec(1,1,'h2E, 'h00,0,2,0,1);
        add_vec(1,1,'hF0, 'h00,0,2,0,1);
        add_vec(1,1,'h2E, 'h00,0,2,0,1);
        add_vec(1,1,'h5A, 'h35,1,0,0,1);
        add_vec(1,0,'h00, 'h35,0,0,0,1);
        add_vec(1,1,'h36, 'h35,0,1,0,1);
        add_vec(1,1,'h46, 'h35,0,2,0,1);
        add_vec(1,1,'h5A, 'h35,0,0,1,1);
        add_vec(1,0,'h00, 'h35,0,0,0,1);
        add_vec(1,1,'h16, 'h35,0,1,0,1);
        add_vec(1,1,'h1E, 'h35,0,2,0,1);
        add_vec(1,1,'h26, 'h35,0,2,0,1);
        add_vec(1,1,'h66, 'h35,0,1,0,1);
        add_vec(1,1,'h5A, 'h01,1,0,0,1);
        add_vec(1,1,'h66, 'h01,0,0,0,1);
        add_vec(1,1,'h5A, 'h01,0,0,0,1);
        add_vec(1,1,'hE0, 'h01,0,0,0,1);
        add_vec(1,1,'h2E, 'h01,0,1,0,1);
        add_vec(1,1,'h46, 'h01,0,2,0,1);
        add_vec(1,1,'h5A, 'h59,1,0,0,1);
        add_vec(1,1,'h36, 'h59,0,1,0,1);
        add_vec(1,1,'h45, 'h59,0,2,0,1);
        add_vec(1,1,'h5A, 'h59,0,0,1,1);
        add_vec(1,1,'h16, 'h59,0,1,0,1);
        add_vec(0,0,'h00, 'h59,0,0,0,0);
        add_vec(1,0,'h00, 'h59,0,0,0,1);
        add_vec(1,1,'h16, 'h59,0,1,0,1);
        add_vec(0,1,'h5A, 'h59,0,0,0,0);
        add_vec(1,0,'h00, 'h59,0,0,0,1);
        add_vec(1,1,'h1C, 'h59,0,0,0,1);

        @(negedge clk);
        @(negedge clk);
        chk("reset.bcd_out", bcd_out, 8'h00);
        chk("reset.digit_count", {6'd0, digit_count}, 8'h00);
        chk("reset.busy", {7'd0, busy}, 8'h00);
        chk("reset.pulses", {5'd0, bcd_valid, entry_err, entry_abort}, 8'h00);
        reset = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].en, vecs[i].tick, vecs[i].code);
            chk($sformatf("vec%0d.bcd_out", i), bcd_out, vecs[i].bcd);
            chk($sformatf("vec%0d.bcd_valid", i), {7'd0, bcd_valid}, {7'd0, vecs[i].valid});
            chk($sformatf("vec%0d.digit_count", i), {6'd0, digit_count}, {6'd0, vecs[i].cnt});
            chk($sformatf("vec%0d.entry_err", i), {7'd0, entry_err}, {7'd0, vecs[i].err});
            chk($sformatf("vec%0d.busy", i), {7'd0, busy}, {7'd0, vecs[i].busy});
        end

        // Esc in the middle of an entry.
        cycle(1, 1, 8'h25);
        cycle(1, 1, 8'h76);
`ifdef PS2_ESC_ABORT_EN
        chk("esc.abort", {7'd0, entry_abort}, 8'h01);
        chk("esc.count", {6'd0, digit_count}, 8'h00);
        cycle(1, 1, 8'h5A);
        chk("esc.enter_ignored", {7'd0, bcd_valid}, 8'h00);
        chk("esc.bcd_hold", bcd_out, 8'h59);
`else
        chk("esc.abort", {7'd0, entry_abort}, 8'h00);
        chk("esc.count", {6'd0, digit_count}, 8'h01);
        cycle(1, 1, 8'h5A);
        chk("esc.commit", {7'd0, bcd_valid}, 8'h01);
        chk("esc.bcd_out", bcd_out, 8'h04);
`endif
        cycle(1, 0, 8'h00);
        chk("esc.abort_one_cycle", {7'd0, entry_abort}, 8'h00);

        // Reset in the middle of an entry discards the partial digit.
        cycle(1, 1, 8'h16);
        reset = 1'b1;
        #1;
        chk("midreset.count", {6'd0, digit_count}, 8'h00);
        chk("midreset.bcd_out", bcd_out, 8'h00);
        chk("midreset.busy", {7'd0, busy}, 8'h00);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(1, 0, 8'h00);
        chk("midreset.no_pulse", {6'd0, bcd_valid, entry_err}, 8'h00);
        cycle(1, 1, 8'h5A);
        chk("midreset.enter_ignored", {7'd0, bcd_valid}, 8'h00);
        chk("midreset.bcd_zero", bcd_out, 8'h00);
        chk("midreset.count_zero", {6'd0, digit_count}, 8'h00);

        // Randomized codes against the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            bit en, tick;
            logic [7:0] code;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: code = dcodes[$urandom_range(0, 9)];
                5: code = 8'hF0;
                6: code = 8'h66;
                7: code = 8'h5A;
                8: code = ($urandom_range(0, 1) != 0) ? 8'h76 : 8'hE0;
                default: code = 8'($urandom);
            endcase
            en = ($urandom_range(0, 29) != 0);
            tick = ($urandom_range(0, 2) == 0);
            cycle(en, tick, code);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
